// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding, parity sense
// constants and the legal range of the data-bit width.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_BREAK     = 3'd5,
    ST_BREAK_END = 3'd6
  } state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;

  function automatic logic parity_bit(input logic data_xor, input logic odd);
    return data_xor ^ (odd == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period counter: counts 0..D-1 while running and strobes
// bit_end on the last clock of each bit. A load restarts the count at 0.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             run,
  input  logic [DIV_W-1:0] div,
  output logic             bit_end
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt;

  assign bit_end = run && (cnt == div_q - DIV_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= DIV_W'(1);
      cnt   <= '0;
    end else if (load) begin
      // a divisor of 0 behaves as 1 clock per bit
      div_q <= (div == '0) ? DIV_W'(1) : div;
      cnt   <= '0;
    end else if (run) begin
      cnt <= bit_end ? '0 : cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with valid/ready input, optional parity and 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the brk_req line-break generator.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int DIV_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_W-1:0]     cfg_div,
  input  logic                 cfg_parity_en,
  input  logic                 cfg_parity_odd,
  input  logic                 cfg_two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk_req,
`endif
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_BITS-1:0] s_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int IDX_W = $clog2(DATA_BITS);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_width
    $error("uart_tx_frame: DATA_BITS out of range");
  end

  state_t               state, state_nxt;
  logic                 brk;
  logic                 accept;
  logic                 bit_end;
  logic                 last_data;
  logic                 last_stop;
  logic                 cnt_load;
  logic                 cnt_run;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 par_q;
  logic                 par_en_q;
  logic                 two_stop_q;
  logic                 stop_idx;

`ifdef UART_TX_BREAK_EN
  assign brk = brk_req;
`else
  assign brk = 1'b0;
`endif

  assign last_data  = (bit_idx == IDX_W'(DATA_BITS - 1));
  assign last_stop  = (state == ST_STOP) && bit_end && (!two_stop_q || stop_idx);
  assign frame_done = last_stop;
  // ready on the final stop clock too, so the next start bit follows with no gap
  assign s_ready    = ((state == ST_IDLE) && !brk) || last_stop;
  assign accept     = s_valid && s_ready;
  assign busy       = (state != ST_IDLE);
  assign cnt_load   = accept || ((state == ST_BREAK) && !brk);
  assign cnt_run    = (state != ST_IDLE) && (state != ST_BREAK);

  uart_baud_cnt #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (cnt_load),
    .run     (cnt_run),
    .div     (cfg_div),
    .bit_end (bit_end)
  );

  always_comb begin
    state_nxt = state;
    tx        = 1'b1;
    unique case (state)
      ST_IDLE: begin
        if (accept)   state_nxt = ST_START;
        else if (brk) state_nxt = ST_BREAK;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_end) state_nxt = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg[0];
        if (bit_end && last_data) state_nxt = par_en_q ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: begin
        tx = par_q;
        if (bit_end) state_nxt = ST_STOP;
      end
      ST_STOP: begin
        if (last_stop) state_nxt = accept ? ST_START : ST_IDLE;
      end
`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        tx = 1'b0;
        if (!brk) state_nxt = ST_BREAK_END;
      end
      ST_BREAK_END: begin
        if (bit_end) state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_en_q   <= 1'b0;
      two_stop_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        bit_idx    <= '0;
        stop_idx   <= 1'b0;
        par_en_q   <= cfg_parity_en;
        two_stop_q <= cfg_two_stop;
      end else if (bit_end) begin
        if (state == ST_DATA) bit_idx <= bit_idx + IDX_W'(1);
        if (state == ST_STOP) stop_idx <= 1'b1;
      end
    end
  end

  // character and parity are captured at acceptance; datapath needs no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      shreg <= s_data;
      par_q <= parity_bit(^s_data, cfg_parity_odd);
    end else if (bit_end && (state == ST_DATA)) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames with hand-computed bit
// sequences, plus back-to-back, mid-frame reset and (optionally) break cases.
module tb_uart_tx_frame;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cfg_div;
  logic        cfg_parity_en, cfg_parity_odd, cfg_two_stop;
  logic        s_valid, s_ready;
  logic [7:0]  s_data;
  logic        tx, busy, frame_done;
  logic        s_valid5, s_ready5;
  logic [4:0]  s_data5;
  logic        tx5, busy5, frame_done5;
`ifdef UART_TX_BREAK_EN
  logic        brk_req;
`endif

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_BITS(8), .DIV_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop(cfg_two_stop),
`ifdef UART_TX_BREAK_EN
    .brk_req(brk_req),
`endif
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  uart_tx_frame #(.DATA_BITS(5), .DIV_W(16)) dut5 (
    .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div),
    .cfg_parity_en(cfg_parity_en), .cfg_parity_odd(cfg_parity_odd),
    .cfg_two_stop(cfg_two_stop),
`ifdef UART_TX_BREAK_EN
    .brk_req(1'b0),
`endif
    .s_valid(s_valid5), .s_ready(s_ready5), .s_data(s_data5),
    .tx(tx5), .busy(busy5), .frame_done(frame_done5)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    logic [15:0] div;
    logic [15:0] mid_div;
    logic [7:0]  data;
    logic        par_en;
    logic        par_odd;
    logic        two_stop;
    logic        five;
    int          nbits;
    int          d;
    logic [11:0] seq;
  } vec_t;

  vec_t vecs[9];

  task automatic run_frame(input vec_t v, input string tag);
    int   n, tx_err, busy_err, done_cnt, done_at;
    logic t, bz, dn, rdy;
    n = v.nbits * v.d;
    tx_err = 0; busy_err = 0; done_cnt = 0; done_at = -1;
    @(negedge clk);
    cfg_div        = v.div;
    cfg_parity_en  = v.par_en;
    cfg_parity_odd = v.par_odd;
    cfg_two_stop   = v.two_stop;
    if (v.five) begin
      s_valid5 = 1'b1; s_data5 = v.data[4:0];
      check({tag, " ready"}, int'(s_ready5), 1);
    end else begin
      s_valid = 1'b1; s_data = v.data;
      check({tag, " ready"}, int'(s_ready), 1);
    end
    @(posedge clk);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == 1) begin
        s_valid = 1'b0; s_valid5 = 1'b0;
        s_data = ~s_data; s_data5 = ~s_data5;
      end
      if (c == 2) cfg_div = v.mid_div;
      t  = v.five ? tx5 : tx;
      bz = v.five ? busy5 : busy;
      dn = v.five ? frame_done5 : frame_done;
      if (t !== v.seq[(c-1)/v.d]) tx_err++;
      if (bz !== 1'b1) busy_err++;
      if (dn === 1'b1) begin done_cnt++; done_at = c; end
    end
    check({tag, " tx bit errors"}, tx_err, 0);
    check({tag, " busy low cycles"}, busy_err, 0);
    check({tag, " done pulses"}, done_cnt, 1);
    check({tag, " done cycle"}, done_at, n);
    @(negedge clk);
    t   = v.five ? tx5 : tx;
    bz  = v.five ? busy5 : busy;
    rdy = v.five ? s_ready5 : s_ready;
    check({tag, " idle tx/busy/ready"}, int'({t, bz, rdy}), 3'b101);
  endtask

  initial begin
    int tx_err, busy_err, done_cnt, rdy30;
    int done_at[2];
    logic exp_bit;
    int b, w;

    vecs[0] = '{16'd4, 16'd4, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10, 4, 12'h34A};
    vecs[1] = '{16'd2, 16'd2, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 11, 2, 12'h54A};
    vecs[2] = '{16'd2, 16'd2, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 11, 2, 12'h74A};
    vecs[3] = '{16'd2, 16'd2, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0, 12, 2, 12'hD4A};
    vecs[4] = '{16'd0, 16'd0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1, 12'h278};
    vecs[5] = '{16'd3, 16'd3, 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 12, 3, 12'hC02};
    vecs[6] = '{16'd4, 16'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10, 4, 12'h34A};
    vecs[7] = '{16'd8, 16'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 10, 8, 12'h34A};
    vecs[8] = '{16'd2, 16'd2, 8'h16, 1'b1, 1'b0, 1'b0, 1'b1,  8, 2, 12'h0EC};

    rst_n = 1'b0;
    cfg_div = 16'd4; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_two_stop = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; s_valid5 = 1'b0; s_data5 = 5'h00;
`ifdef UART_TX_BREAK_EN
    brk_req = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset tx/busy/ready/done", int'({tx, busy, s_ready, frame_done}), 4'b1010);
    check("reset5 tx/busy/ready/done", int'({tx5, busy5, s_ready5, frame_done5}), 4'b1010);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_frame(vecs[i], $sformatf("vec%0d", i));

    // back-to-back 8'h00 then 8'hFF with s_valid held, D=3
    @(negedge clk);
    cfg_div = 16'd3; cfg_parity_en = 1'b0; cfg_two_stop = 1'b0;
    s_valid = 1'b1; s_data = 8'h00;
    tx_err = 0; busy_err = 0; done_cnt = 0; rdy30 = 0;
    done_at[0] = -1; done_at[1] = -1;
    @(posedge clk);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) s_data = 8'hFF;
      if (c == 30) rdy30 = int'(s_ready);
      if (c == 31) s_valid = 1'b0;
      b = (c - 1) / 3;
      w = b % 10;
      if (w == 0) exp_bit = 1'b0;
      else if (w == 9) exp_bit = 1'b1;
      else exp_bit = (b >= 10);
      if (tx !== exp_bit) tx_err++;
      if (busy !== 1'b1) busy_err++;
      if (frame_done === 1'b1) begin
        if (done_cnt < 2) done_at[done_cnt] = c;
        done_cnt++;
      end
    end
    check("b2b tx bit errors", tx_err, 0);
    check("b2b busy low cycles", busy_err, 0);
    check("b2b ready on last stop", rdy30, 1);
    check("b2b done pulses", done_cnt, 2);
    check("b2b first done", done_at[0], 30);
    check("b2b second done", done_at[1], 60);
    @(negedge clk);
    check("b2b idle busy", int'(busy), 0);

    // reset during data bit 3
    @(negedge clk);
    cfg_div = 16'd4; s_valid = 1'b1; s_data = 8'hA5;
    @(posedge clk);
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) s_valid = 1'b0;
    end
    check("pre-reset busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid reset tx/busy/ready/done", int'({tx, busy, s_ready, frame_done}), 4'b1010);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(vecs[0], "post-reset");

`ifdef UART_TX_BREAK_EN
    begin
      int low_cnt, end_err, done_brk, rdy55;
      low_cnt = 0; end_err = 0; done_brk = 0; rdy55 = 0;
      @(negedge clk);
      cfg_div = 16'd4; brk_req = 1'b1;
      #1;
      check("break ready low", int'(s_ready), 0);
      for (int c = 1; c <= 60; c++) begin
        @(negedge clk);
        if (c <= 50 && tx === 1'b0) low_cnt++;
        if (c > 50 && c <= 54 && !(tx === 1'b1 && busy === 1'b1)) end_err++;
        if (c == 55) rdy55 = int'({s_ready, busy});
        if (frame_done === 1'b1) done_brk++;
        if (c == 50) brk_req = 1'b0;
      end
      check("break low cycles", low_cnt, 50);
      check("break end high cycles", end_err, 0);
      check("break then ready/busy", rdy55, 2'b10);
      check("break done pulses", done_brk, 0);
    end
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised next-generation UART transmitter. It serialises one character per frame with configurable data width, optional even/odd parity, 1 or 2 stop bits and a runtime baud divisor. Input is a valid/ready stream, so frames can be sent back-to-back with no idle gap. It sits between the bridge's byte stream (the SPI-side receive path or a FIFO) and the UART TX pin.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_div  in  DIV_W  clocks per bit; 0 is treated as 1.
- cfg_parity_en  in  1  when 1, a parity bit follows the data bits.
- cfg_parity_odd  in  1  when 1, parity is odd; when 0, parity is even.
- cfg_two_stop  in  1  when 1, two stop bits; when 0, one.
- s_valid  in  1  upstream has a character.
- s_ready  out  1  block can accept a character this cycle.
- s_data  in  DATA_BITS  character to send, LSB first.
- tx  out  1  serial line; idles high.
- busy  out  1  a frame, or a break when the feature is enabled, is in progress.
- frame_done  out  1  one-cycle pulse on the last clock of the final stop bit.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - tx=1, busy=0, frame_done=0, state=IDLE, s_ready=1.
  - Reset mid-frame aborts the frame; tx returns to 1 immediately.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - A character is accepted on a clock edge where s_valid && s_ready.
  - At acceptance, s_data, the divisor (max(cfg_div,1)), parity enable/sense and stop count are latched. Config changes mid-frame have no effect.
- s_ready is high in IDLE, and also on the last clock of the final stop bit. This allows zero-gap back-to-back frames.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA.
  - DATA -> PARITY or STOP after DATA_BITS bits.
  - PARITY -> STOP.
  - STOP -> START if a new accept occurs on the last stop clock; otherwise STOP -> IDLE.
- Timing:
  - The start bit drives tx=0 from the clock after acceptance.
  - Every bit lasts exactly D clocks, where D is the latched divisor; a bit counter of width DIV_W counts 0..D-1.
  - Frame length = (1 + DATA_BITS + P + S) x D clocks, where P = parity enabled (0/1) and S = stop bits (1 or 2).
- Parity bit = XOR of all data bits, inverted when odd parity is selected.
- busy is 1 from the clock after acceptance until the clock after the last stop clock, unless a new frame was accepted on that last stop clock.
- frame_done pulses on the last clock of every frame, including one chained back-to-back.
- s_valid without s_ready: no effect. s_data may change freely while not accepted.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- With the macro defined:
  - Adds input brk_req (1 bit).
  - In IDLE with brk_req=1: tx=0, busy=1, s_ready=0; state BREAK.
  - On brk_req falling: tx=1 for D clocks (state BREAK_END), then IDLE and s_ready=1.
  - brk_req during a frame is ignored until the frame ends.
  - frame_done does not pulse for a break.
- Without the macro: no brk_req port, no BREAK/BREAK_END states.

Decomposition:
- Shared package/header uart_pkg:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP, BREAK, BREAK_END);
  - parity-mode constants;
  - legal DATA_BITS bounds.
- One natural sub-module, uart_baud_cnt:
  - loadable divisor counter producing a bit_end strobe on count D-1;
  - restarts on frame accept.

Test Plan:
- Basic frame: D=4, 8'hA5, parity off, 1 stop.
  - Expect tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 clocks.
  - Expect 40 clocks total and frame_done on clock 40.
- Parity: D=2, 8'hA5, parity on.
  - Even: parity bit 0. Odd: parity bit 1.
  - 2 stop bits: frame is 24 clocks.
- Back-to-back: s_valid held, 8'h00 then 8'hFF, D=3.
  - Second start bit directly follows the first stop bit; no gap.
  - Total 60 clocks; two frame_done pulses 30 clocks apart.
  - busy stays continuously high.
- Edge config:
  - cfg_div=0 gives 1-clock bits.
  - cfg_div changed 4->8 mid-frame: current frame keeps 4, next frame uses 8.
  - DATA_BITS=5 build: 8-bit frame with 5 data bits.
- Reset mid-frame: assert rst_n=0 during DATA bit 3.
  - Expect tx=1, busy=0, s_ready=1 immediately.
  - Next accept sends a clean frame.
- Break (UART_TX_BREAK_EN): brk_req high for 50 clocks, D=4.
  - Expect tx=0 for 50 clocks, then tx=1 for 4 clocks, then s_ready=1, with no frame_done.
